// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants, segment type and digit-select helper for the scan driver
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int MAX_DIGITS = 8;

    // Segment order is {a,b,c,d,e,f,g}, a in the MSB
    localparam seg7_t SEG_0     = 7'b1111110;
    localparam seg7_t SEG_1     = 7'b0110000;
    localparam seg7_t SEG_2     = 7'b1101101;
    localparam seg7_t SEG_3     = 7'b1111001;
    localparam seg7_t SEG_4     = 7'b0110011;
    localparam seg7_t SEG_5     = 7'b1011011;
    localparam seg7_t SEG_6     = 7'b1011111;
    localparam seg7_t SEG_7     = 7'b1110000;
    localparam seg7_t SEG_8     = 7'b1111111;
    localparam seg7_t SEG_9     = 7'b1111011;
    localparam seg7_t SEG_A     = 7'b1110111;
    localparam seg7_t SEG_B     = 7'b0011111;
    localparam seg7_t SEG_C     = 7'b1001110;
    localparam seg7_t SEG_D     = 7'b0111101;
    localparam seg7_t SEG_E     = 7'b1001111;
    localparam seg7_t SEG_F     = 7'b1000111;
    localparam seg7_t SEG_BLANK = 7'b0000000;

    function automatic logic [MAX_DIGITS-1:0] digit_mask(input int unsigned n);
        return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << n;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: valid/ready word-load channel carrying digit nibbles and decimal points
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*NUM_DIGITS-1:0] in_data;
    logic [NUM_DIGITS-1:0]   in_dp;

    modport master (output in_valid, output in_data, output in_dp, input in_ready);
    modport slave  (input in_valid, input in_data, input in_dp, output in_ready);

endinterface

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode: nibble to 7-segment glyph, codes 10..15 blank unless hex mode is set
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_hex_mode,
    output seg7_t      o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = i_hex_mode ? SEG_A : SEG_BLANK;
            4'hB: o_seg = i_hex_mode ? SEG_B : SEG_BLANK;
            4'hC: o_seg = i_hex_mode ? SEG_C : SEG_BLANK;
            4'hD: o_seg = i_hex_mode ? SEG_D : SEG_BLANK;
            4'hE: o_seg = i_hex_mode ? SEG_E : SEG_BLANK;
            4'hF: o_seg = i_hex_mode ? SEG_F : SEG_BLANK;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scanner with frame-aligned double-buffered updates
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_blank_lz,
    seg7_scan_driver_if.slave     s_if,
    output seg7_t                 o_seg,
    output logic                  o_dp,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam int   PW  = $clog2(SCAN_DIV);
    localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic HEX = (HEX_MODE != 0);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;
    logic                    r_in_ready;

    logic                  w_tick;
    logic                  w_frame;
    logic                  w_xfer;
    logic                  w_load;
    logic                  w_pend_next;
    logic                  w_sup;
    logic                  w_dp;
    logic [3:0]            w_nib;
    logic [NUM_DIGITS-1:0] w_an;
    seg7_t                 w_glyph;
    seg7_t                 w_seg;

    assign s_if.in_ready = r_in_ready;

    always_comb begin
        logic v_zero;
        w_tick      = i_en && (r_presc == PW'(SCAN_DIV - 1));
        w_frame     = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
        w_xfer      = s_if.in_valid && r_in_ready;
        // While disabled nothing scans, so a pending word is adopted at once to keep the channel moving
        w_load      = r_pend_valid && (w_frame || !i_en);
        w_pend_next = w_xfer || (r_pend_valid && !w_load);
        w_an        = NUM_DIGITS'(digit_mask(32'(r_idx)));
        w_nib       = 4'd0;
        w_dp        = 1'b0;
        w_sup       = 1'b0;
        v_zero      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_zero = v_zero && (r_disp[4*k +: 4] == 4'd0);
            if (r_idx == IW'(k)) begin
                w_nib = r_disp[4*k +: 4];
                w_dp  = r_disp_dp[k];
                w_sup = i_blank_lz && (k != 0) && v_zero;
            end
        end
    end

    seg7_glyph_decode u_decode (
        .i_nib      (w_nib),
        .i_hex_mode (HEX),
        .o_seg      (w_glyph)
    );

    assign w_seg = w_sup ? SEG_BLANK : w_glyph;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_disp_dp    <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            o_seg        <= {7{POL}};
            o_dp         <= POL;
            o_an         <= {NUM_DIGITS{POL}};
        end else begin
            if (i_en) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) r_idx <= w_frame ? '0 : r_idx + 1'b1;
            end
            if (w_load) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
            if (w_xfer) begin
                r_pend    <= s_if.in_data;
                r_pend_dp <= s_if.in_dp;
            end
            r_pend_valid <= w_pend_next;
            r_in_ready   <= !w_pend_next;
            o_seg        <= {7{POL}} ^ (i_en ? w_seg : SEG_BLANK);
            o_dp         <= POL ^ (i_en && w_dp);
            o_an         <= {NUM_DIGITS{POL}} ^ (i_en ? w_an : '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: three builds (BCD, hex, active-low) on shared stimulus against a frame-level display model
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int S = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        blz = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dpin = '0;

    logic [6:0] seg [3];
    logic       dpo [3];
    logic [3:0] an  [3];

    int errs = 0;
    int checks = 0;

    int          t;
    logic [15:0] disp, pdata;
    logic [3:0]  ddp, pdp;
    bit          pv;
    logic [6:0]  e_seg [3];
    logic        e_dp  [3];
    logic [3:0]  e_an  [3];
    bit          e_ready;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus0 ();
    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus1 ();
    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus2 ();

    assign bus0.in_valid = valid;
    assign bus0.in_data  = data;
    assign bus0.in_dp    = dpin;
    assign bus1.in_valid = valid;
    assign bus1.in_data  = data;
    assign bus1.in_dp    = dpin;
    assign bus2.in_valid = valid;
    assign bus2.in_data  = data;
    assign bus2.in_dp    = dpin;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .HEX_MODE(0), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst(rst), .i_en(en), .i_blank_lz(blz), .s_if(bus0),
        .o_seg(seg[0]), .o_dp(dpo[0]), .o_an(an[0])
    );
    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .HEX_MODE(1), .ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst(rst), .i_en(en), .i_blank_lz(blz), .s_if(bus1),
        .o_seg(seg[1]), .o_dp(dpo[1]), .o_an(an[1])
    );
    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .HEX_MODE(0), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .i_en(en), .i_blank_lz(blz), .s_if(bus2),
        .o_seg(seg[2]), .o_dp(dpo[2]), .o_an(an[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predicts what the pins show after the coming edge, then advances the display model
    task automatic model_step();
        int         dig;
        logic [3:0] nib;
        logic [6:0] s;
        logic       d;
        logic [3:0] a;
        bit         xfer, frame;
        dig = (t / S) % N;
        for (int i = 0; i < 3; i++) begin
            if (rst || !en) begin
                s = '0; d = 1'b0; a = '0;
            end else begin
                nib = disp[4*dig +: 4];
                if (blz && dig > 0 && (disp >> (4*dig)) == 16'd0) s = 7'd0;
                else if (nib > 4'd9 && i != 1) s = 7'd0;
                else s = GLYPH[nib];
                d = ddp[dig];
                a = 4'(1 << dig);
            end
            if (i == 2) begin
                s = ~s; d = ~d; a = ~a;
            end
            e_seg[i] = s; e_dp[i] = d; e_an[i] = a;
        end
        if (rst) begin
            t = 0; disp = '0; ddp = '0; pdata = '0; pdp = '0; pv = 0;
        end else begin
            xfer  = valid && !pv;
            frame = en && (t % S == S - 1) && (dig == N - 1);
            if (pv && (!en || frame)) begin
                disp = pdata; ddp = pdp; pv = 0;
            end
            if (xfer) begin
                pdata = data; pdp = dpin; pv = 1;
            end
            if (en) t = (t + 1) % (N * S);
        end
        e_ready = !pv;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("seg%0d", i), seg[i], e_seg[i]);
            check($sformatf("dp%0d", i), dpo[i], e_dp[i]);
            check($sformatf("an%0d", i), an[i], e_an[i]);
        end
        check("ready0", bus0.in_ready, e_ready);
        check("ready1", bus1.in_ready, e_ready);
        check("ready2", bus2.in_ready, e_ready);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] p);
        bit go;
        go = 0;
        valid = 1'b1; data = d; dpin = p;
        for (int n = 0; n < 200 && !go; n++) begin
            go = !pv;
            cycle();
        end
        if (!go) check("send_timeout", 32'd0, 32'd1);
        valid = 1'b0;
    endtask

    initial begin
        t = 0; disp = '0; ddp = '0; pdata = '0; pdp = '0; pv = 0;
        idle(3);
        check("rst_seg_al", seg[2], 32'h7F);
        check("rst_an_al", an[2], 32'hF);
        check("rst_dp_al", dpo[2], 32'h1);
        check("rst_an", an[0], 32'h0);
        rst = 1'b0;
        idle(2);
        en = 1'b1;
        idle(40);
        send(16'h1234, 4'b0100);
        idle(40);
        blz = 1'b1;
        send(16'h0070, 4'b0000);
        idle(40);
        blz = 1'b0;
        idle(20);
        send(16'h00F0, 4'b0000);
        idle(20);
        send(16'hABCD, 4'b1001);
        idle(20);
        send(16'h1111, 4'b1111);
        send(16'h2222, 4'b0000);
        idle(40);
        en = 1'b0;
        send(16'h3333, 4'b0001);
        idle(5);
        en = 1'b1;
        idle(10);
        for (int n = 0; n < 20 && ((t / S) % N) != 2; n++) cycle();
        cycle();
        send(16'h5555, 4'b1111);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(40);
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) blz = ~blz;
            valid = ($urandom_range(0, 3) == 0);
            data  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dpin  = 4'($urandom);
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit, time-multiplexed 7-segment display driver. Accepts a packed word of NUM_DIGITS nibbles over a valid/ready handshake and double-buffers it so updates land only at frame boundaries, with no tearing. Scans one digit at a time with per-digit decimal points, optional leading-zero suppression, BCD or hex glyphs, and selectable output polarity. Sits between status/counter logic and the board-level display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 1000, clock cycles each digit stays lit (>=2)
HEX_MODE, 0, 0 = BCD (codes 10..15 blank), 1 = hex glyphs A,b,C,d,E,F
ACTIVE_LOW, 0, 1 = seg/dp/an outputs inverted (common-anode boards)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  display enable; 0 = all outputs inactive
blank_lz  in  1  1 = suppress leading zeros
in_valid  in  1  new display word offered
in_ready  out  1  pending buffer free
in_data  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is least significant
in_dp  in  NUM_DIGITS  decimal point per digit
seg  out  7  {a,b,c,d,e,f,g}, a = MSB
dp  out  1  decimal point of the current digit
an  out  NUM_DIGITS  one-hot digit select

Behaviour:
- Reset: prescaler=0, digit index=0, display and pending registers=0, pend_valid=0. seg, dp and an are inactive: all 0, or all 1 when ACTIVE_LOW.
- in_ready = !pend_valid, as a registered flag. Transfer occurs when in_valid && in_ready. in_data and in_dp are captured into pending, and pend_valid is set.
- Prescaler counts 0..SCAN_DIV-1. The tick is the terminal count. On tick, the index advances and wraps NUM_DIGITS-1 -> 0.
- Frame boundary is a tick whose next index is 0. At a frame boundary, if pend_valid=1, pending copies to display and pend_valid clears, so in_ready rises the next cycle.
- If a transfer and a frame boundary occur in the same cycle, the new word goes to pending only. There is no bypass, and it is displayed at the following boundary.
- Outputs are registered. seg, dp and an reflect the index and display state of the previous cycle, a 1-cycle latency.
- Each digit is lit for exactly SCAN_DIV cycles. Frame period is NUM_DIGITS*SCAN_DIV cycles.
- an = one-hot(index).
- Glyphs, BCD: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Glyphs, HEX_MODE=1 adds: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Glyphs, HEX_MODE=0: codes 10..15 give 0000000.
- Leading-zero suppression: when blank_lz=1, digit k has seg=0000000 if all display nibbles k..NUM_DIGITS-1 are zero.
  - Digit 0 is never suppressed.
  - an and dp are unaffected by suppression.
- en=0:
  - seg, dp and an are inactive from the next cycle.
  - Prescaler and index hold.
  - Pending copies to display every cycle that pend_valid=1, so the handshake never stalls.
  - On return to en=1, scanning resumes at the held index and count.
- ACTIVE_LOW=1 inverts seg, dp and an after all other logic, including the inactive state.
- Reset mid-frame: all state returns to reset values next cycle, and any pending word is discarded.

Decomposition:
- seg7_pkg holds:
  - SEG_* 7-bit glyph constants 0..F and SEG_BLANK
  - typedef seg7_t (logic [6:0])
  - function digit_mask(n) (one-hot)
- One sub-module: seg7_glyph_decode. Combinational; 4-bit nibble plus hex_mode -> seg7_t. It generalises the single-digit decoder and is instantiated once on the muxed nibble.
- Top level holds prescaler, index, double buffer, LZ logic and output registers.

Test Plan:
- All directed scenarios use NUM_DIGITS=4, SCAN_DIV=4.
- Reset then en=1, no writes -> an=0001 and seg=1111110 two cycles after reset release (1-cycle latency), each digit lit 4 cycles, an sequence 0001,0010,0100,1000 repeating.
- Write in_data=0x1234, in_dp=0b0100 -> after the next frame boundary, an=0001 seg=0110011; an=0010 seg=1111001; an=0100 seg=1101101 dp=1; an=1000 seg=0110000.
- Write 0x0070 with blank_lz=1 -> digits 3 and 2 give seg=0000000 with an still cycling, digit 1 seg=1110000, digit 0 seg=1111110. With blank_lz=0, digits 3 and 2 give 1111110.
- Glyph modes:
  - HEX_MODE=0, 0x00F0 -> digit 1 seg=0000000.
  - HEX_MODE=1, 0xABCD -> digit 0 gives 0111101, digit 1 1001110, digit 2 0011111, digit 3 1110111.
- Back-to-back writes 0x1111 then 0x2222 -> in_ready=0 after the first write until the boundary. 0x1111 is displayed for one full frame, 0x2222 is accepted and shown the following frame, and no mixed frame occurs.
- ACTIVE_LOW=1 build, reset and en=0 -> seg=1111111, an=1111, dp=1. Assert rst mid-digit 2 -> next cycle all inactive, and pending 0x5555 is not displayed after release.
